// File: rtl/d_inv_seq.sv
// Sequencer for the diagonal reciprocal engine: fetch entry, clear+run engine, emit result with index.
// Optional macro DINV_TIMEOUT_EN aborts a RUN that exceeds TIMEOUT_CYC cycles and emits SAT_VAL.
module d_inv_seq #(
  parameter int          IDX_W       = 6,
  parameter logic [15:0] SAT_VAL     = 16'h7FFF,
  parameter int          TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             eng_rst,
  output logic             eng_en,
  output logic [15:0]      eng_din,
  input  logic [15:0]      eng_dout,
  input  logic             eng_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             busy,
  output logic             done,
  output logic             zero_err,
  output logic             timeout_err
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CLR, S_RUN, S_EMIT, S_DONE} state_t;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic [15:0]      eng_din_q, eng_din_d;
  logic [15:0]      out_data_q, out_data_d;
  logic             zero_err_q, zero_err_d;
  logic             in_ready_q, in_ready_d;
  logic             eng_en_q, eng_en_d;
  logic             eng_clr_q, eng_clr_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] len_m1;

`ifdef DINV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout_err_q, timeout_err_d;
`endif

  assign len_m1 = len_q - {{(IDX_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    count_d    = count_q;
    eng_din_d  = eng_din_q;
    out_data_d = out_data_q;
    zero_err_d = zero_err_q;
`ifdef DINV_TIMEOUT_EN
    tmo_d         = tmo_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          zero_err_d = 1'b0;
`ifdef DINV_TIMEOUT_EN
          timeout_err_d = 1'b0;
`endif
          if (len == '0) begin
            state_d = S_DONE;
          end else begin
            len_d   = len;
            count_d = '0;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (in_valid) begin
          eng_din_d = in_data;
          // Zero has no reciprocal: saturate and skip the engine entirely.
          if (in_data == 16'h0000) begin
            out_data_d = SAT_VAL;
            zero_err_d = 1'b1;
            state_d    = S_EMIT;
          end else begin
            state_d = S_CLR;
          end
        end
      end
      S_CLR: begin
        state_d = S_RUN;
`ifdef DINV_TIMEOUT_EN
        tmo_d = '0;
`endif
      end
      S_RUN: begin
        if (eng_flag) begin
          out_data_d = eng_dout;
          state_d    = S_EMIT;
        end
`ifdef DINV_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYC)) begin
          out_data_d    = SAT_VAL;
          timeout_err_d = 1'b1;
          state_d       = S_EMIT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_EMIT: begin
        if (out_ready) begin
          if (count_q == len_m1) begin
            state_d = S_DONE;
          end else begin
            count_d = count_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    in_ready_d  = (state_d == S_FETCH);
    eng_en_d    = (state_d == S_RUN);
    eng_clr_d   = (state_d == S_CLR);
    out_valid_d = (state_d == S_EMIT);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      count_q     <= '0;
      eng_din_q   <= '0;
      out_data_q  <= '0;
      zero_err_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      eng_en_q    <= 1'b0;
      eng_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DINV_TIMEOUT_EN
      tmo_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      eng_din_q   <= eng_din_d;
      out_data_q  <= out_data_d;
      zero_err_q  <= zero_err_d;
      in_ready_q  <= in_ready_d;
      eng_en_q    <= eng_en_d;
      eng_clr_q   <= eng_clr_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef DINV_TIMEOUT_EN
      tmo_q         <= tmo_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign eng_rst   = rst | eng_clr_q;
  assign eng_en    = eng_en_q;
  assign eng_din   = eng_din_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = count_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign zero_err  = zero_err_q;
`ifdef DINV_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_d_inv_seq.sv
// Directed bench for d_inv_seq with a sticky-flag engine model and an expected-result queue.
module tb_d_inv_seq;
  localparam int IDX_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [IDX_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             eng_rst;
  logic             eng_en;
  logic [15:0]      eng_din;
  logic [15:0]      eng_dout;
  logic             eng_flag;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic [IDX_W-1:0] out_idx;
  logic             busy;
  logic             done;
  logic             zero_err;
  logic             timeout_err;

  d_inv_seq #(.IDX_W(IDX_W), .SAT_VAL(16'h7FFF), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .eng_rst(eng_rst), .eng_en(eng_en), .eng_din(eng_din),
    .eng_dout(eng_dout), .eng_flag(eng_flag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .busy(busy), .done(done), .zero_err(zero_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Engine model: flag rises 5 enabled cycles after clear, sticky until eng_rst.
  logic       eng_hang = 1'b0;
  logic [3:0] eng_cnt;
  always @(posedge clk or posedge eng_rst) begin
    if (eng_rst) begin
      eng_cnt  <= '0;
      eng_flag <= 1'b0;
    end else if (eng_en && !eng_hang) begin
      eng_cnt <= eng_cnt + 1'b1;
      if (eng_cnt == 4'd4) eng_flag <= 1'b1;
    end
  end
  assign eng_dout = (eng_din == 16'h0) ? 16'h0 : 16'(32'd4096 / {16'h0, eng_din});

  int n_chk = 0, n_fail = 0;
  int done_cnt = 0, en_cnt = 0, ov_cnt = 0, ir_cnt = 0;
  always @(posedge clk) begin
    if (done)      done_cnt++;
    if (eng_en)    en_cnt++;
    if (out_valid) ov_cnt++;
    if (in_ready)  ir_cnt++;
  end

  logic [IDX_W+15:0] sb[$];

  function automatic logic [15:0] exp_of(logic [15:0] d);
    return (d == 16'h0) ? 16'h7FFF : 16'(32'd4096 / {16'h0, d});
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic do_start(int n);
    start = 1'b1;
    len   = n[IDX_W-1:0];
    tick();
    start = 1'b0;
  endtask

  task automatic accept(logic [15:0] d, int idx);
    int g;
    in_valid = 1'b1;
    in_data  = d;
    g = 0;
    while (!in_ready && g < 50) begin tick(); g++; end
    chk("fetch_wait", in_ready, 1);
    sb.push_back({idx[IDX_W-1:0], exp_of(d)});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic feed(logic [15:0] d, int idx, bit stall);
    int g, en0, ir0;
    logic [15:0]      o_d;
    logic [IDX_W-1:0] o_i;
    logic [IDX_W+15:0] e_v;
    en0 = en_cnt;
    accept(d, idx);
    if (d == 16'h0) chk("zero_latency", out_valid, 1);
    g = 0;
    while (!out_valid && g < 200) begin tick(); g++; end
    chk("out_wait", out_valid, 1);
    if (d == 16'h0) chk("zero_no_eng_en", en_cnt - en0, 0);
    else            chk("eng_din_hold", eng_din, d);
    if (stall) begin
      o_d = out_data;
      o_i = out_idx;
      ir0 = ir_cnt;
      repeat (10) tick();
      chk("stall_data", out_data, o_d);
      chk("stall_idx", out_idx, o_i);
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", ir_cnt - ir0, 0);
    end
    e_v = sb.pop_front();
    chk("out_data", out_data, e_v[15:0]);
    chk("out_idx", out_idx, e_v[IDX_W+15:16]);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int dc0, ir0, ov0, g;
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_ctrl", {in_ready, eng_en, out_valid, done, busy, zero_err, timeout_err}, 0);
    chk("rst_data", {out_data, out_idx, eng_din}, 0);
    chk("rst_eng_rst", eng_rst, 1);
    rst = 1'b0;
    tick();

    // Three nonzero entries through the engine.
    dc0 = done_cnt;
    do_start(3);
    feed(16'd4, 0, 1'b0);
    feed(16'd2, 1, 1'b0);
    feed(16'd1, 2, 1'b0);
    chk("seq1_done", done, 1);
    tick();
    chk("seq1_done_low", done, 0);
    chk("seq1_done_cnt", done_cnt - dc0, 1);
    chk("seq1_zero_err", zero_err, 0);
    chk("seq1_idle", busy, 0);

    // Zero entry bypasses the engine.
    do_start(2);
    feed(16'd0, 0, 1'b0);
    feed(16'd8, 1, 1'b0);
    chk("seq2_done", done, 1);
    chk("seq2_zero_err_done", zero_err, 1);
    tick();
    chk("seq2_zero_err_idle", zero_err, 1);

    // Empty sequence.
    dc0 = done_cnt; ir0 = ir_cnt; ov0 = ov_cnt;
    do_start(0);
    chk("len0_zero_err_clr", zero_err, 0);
    repeat (4) tick();
    chk("len0_done_cnt", done_cnt - dc0, 1);
    chk("len0_no_in_ready", ir_cnt - ir0, 0);
    chk("len0_no_out_valid", ov_cnt - ov0, 0);

    // Downstream stall on idx0.
    dc0 = done_cnt;
    do_start(2);
    feed(16'd4, 0, 1'b1);
    feed(16'd2, 1, 1'b0);
    tick();
    chk("stall_seq_done", done_cnt - dc0, 1);

    // Reset during RUN of element 1.
    do_start(3);
    feed(16'd4, 0, 1'b0);
    accept(16'd2, 1);
    tick();
    chk("run_eng_en", eng_en, 1);
    dc0 = done_cnt; ov0 = ov_cnt;
    rst = 1'b1;
    #1;
    chk("arst_ctrl", {in_ready, eng_en, out_valid, done, busy}, 0);
    chk("arst_data", {out_data, out_idx, eng_din}, 0);
    chk("arst_eng_rst", eng_rst, 1);
    tick();
    rst = 1'b0;
    sb.delete();
    repeat (3) tick();
    chk("arst_no_done", done_cnt - dc0, 0);
    chk("arst_no_out", ov_cnt - ov0, 0);
    do_start(1);
    feed(16'd2, 0, 1'b0);
    chk("post_rst_done", done, 1);
    tick();

    // Engine that never flags.
    eng_hang = 1'b1;
    do_start(1);
    accept(16'd5, 0);
    tick();
    chk("hang_run", eng_en, 1);
`ifdef DINV_TIMEOUT_EN
    g = 0;
    while (!out_valid && g < 200) begin tick(); g++; end
    chk("tmo_latency", g, 65);
    chk("tmo_data", out_data, 16'h7FFF);
    chk("tmo_err", timeout_err, 1);
    void'(sb.pop_front());
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("tmo_done", done, 1);
    tick();
`else
    ov0 = ov_cnt;
    g = 0;
    while (!out_valid && g < 1000) begin tick(); g++; end
    chk("hang_no_out", ov_cnt - ov0, 0);
    chk("hang_busy", busy, 1);
    chk("hang_no_tmo_err", timeout_err, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    tick();
`endif
    eng_hang = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
